// File: rtl/nsa_pkg.sv
// Shared definitions for the nibble-serial adder sequencer: slice width and
// the sequencer state type.
package nsa_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/adder_4bit.sv
// Single 4-bit ripple adder slice with carry-in and carry-out. This is the
// only arithmetic hardware the sequencer owns; wide sums are built by
// reusing it once per nibble.
module adder_4bit
   import nsa_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                cin,
   output logic [NIBBLE_W-1:0] sum,
   output logic                cout
);

   logic [NIBBLE_W:0] carry_chain;

   // Explicit bit-by-bit ripple so the slice stays a true ripple adder
   always_comb begin
      carry_chain[0] = cin;
      for (int i = 0; i < NIBBLE_W; i++) begin
         sum[i]             = a[i] ^ b[i] ^ carry_chain[i];
         carry_chain[i + 1] = (a[i] & b[i]) | (carry_chain[i] & (a[i] ^ b[i]));
      end
   end

   assign cout = carry_chain[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Wide unsigned adder built from one 4-bit slice, one nibble per cycle,
// least significant nibble first. Operands are taken on a valid/ready
// request channel; the sum is offered on a valid/ready response channel.
module nibble_serial_add_ctrl
   import nsa_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start_valid,
   output logic                      start_ready,
   input  logic [NIBBLE_W*NIBBLES-1:0] op_a,
   input  logic [NIBBLE_W*NIBBLES-1:0] op_b,
   input  logic                      cin,
   output logic                      res_valid,
   input  logic                      res_ready,
   output logic [NIBBLE_W*NIBBLES-1:0] res_sum,
   output logic                      res_cout,
   output logic                      busy
);

   localparam int W     = NIBBLE_W * NIBBLES;
   localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

   state_t               state;
   logic [CNT_W-1:0]     cnt;
   logic                 carry;
   logic [W-1:0]         a_reg;
   logic [W-1:0]         b_reg;
   logic [NIBBLE_W-1:0]  a_nib;
   logic [NIBBLE_W-1:0]  b_nib;
   logic [NIBBLE_W-1:0]  slice_sum;
   logic                 slice_cout;

   // Pick the operand nibbles addressed by the nibble counter
   always_comb begin
      a_nib = '0;
      b_nib = '0;
      for (int i = 0; i < NIBBLES; i++) begin
         if (cnt == CNT_W'(i)) begin
            a_nib = a_reg[NIBBLE_W*i +: NIBBLE_W];
            b_nib = b_reg[NIBBLE_W*i +: NIBBLE_W];
         end
      end
   end

   adder_4bit u_slice (
      .a    (a_nib),
      .b    (b_nib),
      .cin  (carry),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   // Sequencer: capture on accept, ripple one nibble per RUN cycle, then
   // hold the result until the consumer retires it
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         carry    <= 1'b0;
         a_reg    <= '0;
         b_reg    <= '0;
         res_sum  <= '0;
         res_cout <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_valid) begin
                  a_reg   <= op_a;
                  b_reg   <= op_b;
                  carry   <= cin;
                  cnt     <= '0;
                  res_sum <= '0;
                  state   <= RUN;
               end
            end
            RUN: begin
               for (int i = 0; i < NIBBLES; i++) begin
                  if (cnt == CNT_W'(i)) begin
                     res_sum[NIBBLE_W*i +: NIBBLE_W] <= slice_sum;
                  end
               end
               carry <= slice_cout;
               if (cnt == LAST_NIB) begin
                  res_cout <= slice_cout;
                  state    <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               if (res_ready) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign start_ready = (state == IDLE) && !rst;
   assign busy        = (state != IDLE);
   assign res_valid   = (state == DONE);

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench for nibble_serial_add_ctrl with NIBBLES=4. A
// transaction-level model predicts handshake and result behaviour every
// cycle; directed scenarios pin the model with hand-computed literals.
module tb_nibble_serial_add_ctrl;

   localparam int NIBBLES = 4;
   localparam int W       = 4 * NIBBLES;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start_valid = 1'b0;
   logic          start_ready;
   logic [W-1:0]  op_a = '0;
   logic [W-1:0]  op_b = '0;
   logic          cin = 1'b0;
   logic          res_valid;
   logic          res_ready = 1'b0;
   logic [W-1:0]  res_sum;
   logic          res_cout;
   logic          busy;

   int vectors     = 0;
   int miscompares = 0;

   nibble_serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
      .clk         (clk),
      .rst         (rst),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .op_a        (op_a),
      .op_b        (op_b),
      .cin         (cin),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_sum     (res_sum),
      .res_cout    (res_cout),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Transaction-level model: one operation in flight, whose result becomes
   // visible NIBBLES edges after the accept edge and is held until retired
   bit           m_known = 1'b0;
   bit           m_busy  = 1'b0;
   bit           m_valid = 1'b0;
   logic [W-1:0] m_sum   = '0;
   logic         m_cout  = 1'b0;
   logic [W:0]   m_exp   = '0;
   int           m_age   = 0;
   int           cyc     = 0;
   int           accepts = 0;
   int           acc_cyc[$];
   logic [W:0]   res_log[$];

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         m_known = 1'b1;
         m_busy  = 1'b0;
         m_valid = 1'b0;
         m_sum   = '0;
         m_cout  = 1'b0;
         m_age   = 0;
      end else if (m_known) begin
         if (!m_busy) begin
            if (start_valid) begin
               m_busy  = 1'b1;
               m_age   = 0;
               m_exp   = {1'b0, op_a} + {1'b0, op_b} + {{W{1'b0}}, cin};
               accepts++;
               acc_cyc.push_back(cyc);
            end
         end else if (!m_valid) begin
            m_age++;
            if (m_age == NIBBLES) begin
               m_valid = 1'b1;
               m_sum   = m_exp[W-1:0];
               m_cout  = m_exp[W];
            end
         end else if (res_ready) begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Every-cycle comparison of the DUT against the model
   always @(negedge clk) begin
      if (m_known) begin
         checkOutput("start_ready", 32'(start_ready), 32'(!m_busy && !rst));
         checkOutput("busy",        32'(busy),        32'(m_busy));
         checkOutput("res_valid",   32'(res_valid),   32'(m_valid));
         if (!m_busy || m_valid) begin
            checkOutput("res_sum",  32'(res_sum),  32'(m_sum));
            checkOutput("res_cout", 32'(res_cout), 32'(m_cout));
         end
      end
   end

   // Record every retired result for the streaming scenario
   always @(negedge clk) begin
      if (res_valid && res_ready) begin
         res_log.push_back({res_cout, res_sum});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request and hold it until the model sees it accepted
   task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      int n0;
      n0          = accepts;
      start_valid = 1'b1;
      op_a        = a;
      op_b        = b;
      cin         = c;
      for (int i = 0; i < 40 && accepts == n0; i++) tick();
      checkOutput("accepted", 32'(accepts != n0), 32'd1);
      start_valid = 1'b0;
      op_a        = W'($urandom);
      op_b        = W'($urandom);
      cin         = 1'($urandom);
   endtask

   // Wait for res_valid; edges counts the accept edge as edge 1
   task automatic waitResult(output int edges);
      edges = 1;
      while (!res_valid && edges < 40) begin
         checkOutput("ready_in_flight", 32'(start_ready), 32'd0);
         checkOutput("busy_in_flight",  32'(busy),        32'd1);
         tick();
         edges++;
      end
      checkOutput("result_seen", 32'(res_valid), 32'd1);
   endtask

   task automatic doOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input logic [W-1:0] exp_sum, input logic exp_cout);
      int edges;
      res_ready = 1'b0;
      applyStimulus(a, b, c);
      waitResult(edges);
      checkOutput("latency",  32'(edges),    32'(NIBBLES + 1));
      checkOutput("lit_sum",  32'(res_sum),  32'(exp_sum));
      checkOutput("lit_cout", 32'(res_cout), 32'(exp_cout));
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask

   initial begin
      int edges;
      int n0;
      tick();
      tick();
      rst = 1'b0;
      @(negedge clk);
      checkOutput("reset_sum",   32'(res_sum),     32'd0);
      checkOutput("reset_ready", 32'(start_ready), 32'd1);

      // Basic sums, full carry ripple, and carry-in with per-nibble carries
      doOp(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0);
      doOp(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
      doOp(16'h9999, 16'h9999, 1'b1, 16'h3333, 1'b1);

      // Stall in DONE with a competing request that must be ignored
      applyStimulus(16'h4444, 16'h2222, 1'b0);
      waitResult(edges);
      n0          = accepts;
      start_valid = 1'b1;
      op_a        = 16'h1111;
      op_b        = 16'h1111;
      for (int i = 0; i < 6; i++) begin
         tick();
         checkOutput("stall_valid", 32'(res_valid), 32'd1);
         checkOutput("stall_sum",   32'(res_sum),   32'h6666);
         checkOutput("stall_cout",  32'(res_cout),  32'd0);
      end
      start_valid = 1'b0;
      res_ready   = 1'b1;
      tick();
      res_ready = 1'b0;
      checkOutput("retire_ready", 32'(start_ready), 32'd1);
      checkOutput("retire_busy",  32'(busy),        32'd0);
      checkOutput("no_capture",   32'(accepts),     32'(n0));

      // Reset in the middle of an operation discards it
      applyStimulus(16'hFFFF, 16'hFFFF, 1'b0);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      checkOutput("abort_valid", 32'(res_valid),   32'd0);
      checkOutput("abort_sum",   32'(res_sum),     32'd0);
      checkOutput("abort_ready", 32'(start_ready), 32'd1);
      doOp(16'h0505, 16'h0606, 1'b0, 16'h0B0B, 1'b0);

      // Back-to-back stream with the consumer always ready
      tick();
      res_ready = 1'b1;
      res_log.delete();
      n0          = accepts;
      start_valid = 1'b1;
      op_a        = 16'h1234;
      op_b        = 16'h4321;
      cin         = 1'b0;
      for (int i = 0; i < 40 && accepts == n0; i++) tick();
      op_a = 16'h8000;
      op_b = 16'h8000;
      for (int i = 0; i < 40 && accepts < n0 + 2; i++) tick();
      start_valid = 1'b0;
      for (int i = 0; i < 40 && res_log.size() < 2; i++) tick();
      checkOutput("stream_count", 32'(res_log.size()), 32'd2);
      if (res_log.size() >= 2 && acc_cyc.size() >= 2) begin
         checkOutput("stream_r0",  32'(res_log[0]), 32'h0_5555);
         checkOutput("stream_r1",  32'(res_log[1]), 32'h1_0000);
         checkOutput("stream_gap", 32'(acc_cyc[acc_cyc.size()-1] - acc_cyc[acc_cyc.size()-2]), 32'd6);
      end

      // Randomized traffic including occasional resets
      for (int i = 0; i < 600; i++) begin
         start_valid = 1'($urandom);
         op_a        = W'($urandom);
         op_b        = W'($urandom);
         cin         = 1'($urandom);
         res_ready   = ($urandom_range(0, 3) != 0);
         rst         = ($urandom_range(0, 63) == 0);
         tick();
      end
      rst         = 1'b0;
      start_valid = 1'b0;
      res_ready   = 1'b1;
      for (int i = 0; i < 10; i++) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
